// File: rtl/trace_frame_rx.sv
// Receive-side deframer for the capture-trace UART stream.
// A frame is PT, KEY and CT fields followed by SAMPLES trace bytes. Text
// fields are staged while they arrive and published together on completion;
// trace bytes stream out through a RAM write port.
module trace_frame_rx #(
    parameter int          PT_BYTES       = 16,
    parameter int          KEY_BYTES      = 16,
    parameter int          CT_BYTES       = 16,
    parameter int          SAMPLES        = 1024,
    parameter int          ADDR_W         = 10,
    parameter int          TIMEOUT_CYCLES = 65536,
    parameter logic [7:0]  DVLD_MARK      = 8'd255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_dv,
    input  logic [7:0]             rx_byte,
    output logic [PT_BYTES*8-1:0]  pt,
    output logic [KEY_BYTES*8-1:0] key,
    output logic [CT_BYTES*8-1:0]  ct,
    output logic                   smp_we,
    output logic [ADDR_W-1:0]      smp_addr,
    output logic [7:0]             smp_data,
    output logic                   mark_found,
    output logic [ADDR_W-1:0]      mark_idx,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic                   busy,
    output logic [15:0]            frame_count
);

    localparam int PT_W   = PT_BYTES * 8;
    localparam int KEY_W  = KEY_BYTES * 8;
    localparam int CT_W   = CT_BYTES * 8;
    localparam int MAX_A  = (PT_BYTES > KEY_BYTES) ? PT_BYTES : KEY_BYTES;
    localparam int MAX_B  = (CT_BYTES > SAMPLES) ? CT_BYTES : SAMPLES;
    localparam int MAX_N  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_N + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_PT, S_KEY, S_CT, S_SMP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [PT_W-1:0]    pt_s_q, pt_s_d, pt_q, pt_d;
    logic [KEY_W-1:0]   key_s_q, key_s_d, key_q, key_d;
    logic [CT_W-1:0]    ct_s_q, ct_s_d, ct_q, ct_d;
    logic               found_s_q, found_s_d;
    logic [ADDR_W-1:0]  idx_s_q, idx_s_d;
    logic               smp_we_q, smp_we_d;
    logic [ADDR_W-1:0]  smp_addr_q, smp_addr_d;
    logic [7:0]         smp_data_q, smp_data_d;
    logic               mark_found_q, mark_found_d;
    logic [ADDR_W-1:0]  mark_idx_q, mark_idx_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic [15:0]        frame_count_q, frame_count_d;

    // Next-state: field sequencing, sample streaming, publication and timeout abort
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pt_s_d        = pt_s_q;
        key_s_d       = key_s_q;
        ct_s_d        = ct_s_q;
        found_s_d     = found_s_q;
        idx_s_d       = idx_s_q;
        pt_d          = pt_q;
        key_d         = key_q;
        ct_d          = ct_q;
        smp_we_d      = 1'b0;
        smp_addr_d    = smp_addr_q;
        smp_data_d    = smp_data_q;
        mark_found_d  = mark_found_q;
        mark_idx_d    = mark_idx_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;

        if (rx_dv || state_q == S_IDLE) tmo_d = '0;
        else                            tmo_d = tmo_q + TMO_W'(1);

        case (state_q)
            S_IDLE: if (rx_dv) begin
                pt_s_d    = PT_W'({pt_s_q, rx_byte});
                found_s_d = 1'b0;
                idx_s_d   = '0;
                if (PT_BYTES == 1) begin
                    cnt_d   = '0;
                    state_d = S_KEY;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_PT;
                end
            end
            S_PT: if (rx_dv) begin
                pt_s_d = PT_W'({pt_s_q, rx_byte});
                if (cnt_q == CNT_W'(PT_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_KEY;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            S_KEY: if (rx_dv) begin
                key_s_d = KEY_W'({key_s_q, rx_byte});
                if (cnt_q == CNT_W'(KEY_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CT;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            S_CT: if (rx_dv) begin
                ct_s_d = CT_W'({ct_s_q, rx_byte});
                if (cnt_q == CNT_W'(CT_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SMP;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            S_SMP: if (rx_dv) begin
                smp_we_d   = 1'b1;
                smp_addr_d = ADDR_W'(cnt_q);
                smp_data_d = rx_byte;
                if (!found_s_q && rx_byte == DVLD_MARK) begin
                    found_s_d = 1'b1;
                    idx_s_d   = ADDR_W'(cnt_q);
                end
                // Publish uses the _d staging so a mark on the final sample counts
                if (cnt_q == CNT_W'(SAMPLES - 1)) begin
                    frame_valid_d = 1'b1;
                    pt_d          = pt_s_q;
                    key_d         = key_s_q;
                    ct_d          = ct_s_q;
                    mark_found_d  = found_s_d;
                    mark_idx_d    = idx_s_d;
                    frame_count_d = frame_count_q + 16'd1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A byte on the terminal count cycle takes priority over the abort
        if (state_q != S_IDLE && !rx_dv && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = '0;
            tmo_d       = '0;
            found_s_d   = 1'b0;
            idx_s_d     = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            pt_s_q        <= '0;
            key_s_q       <= '0;
            ct_s_q        <= '0;
            found_s_q     <= 1'b0;
            idx_s_q       <= '0;
            pt_q          <= '0;
            key_q         <= '0;
            ct_q          <= '0;
            smp_we_q      <= 1'b0;
            smp_addr_q    <= '0;
            smp_data_q    <= '0;
            mark_found_q  <= 1'b0;
            mark_idx_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            pt_s_q        <= pt_s_d;
            key_s_q       <= key_s_d;
            ct_s_q        <= ct_s_d;
            found_s_q     <= found_s_d;
            idx_s_q       <= idx_s_d;
            pt_q          <= pt_d;
            key_q         <= key_d;
            ct_q          <= ct_d;
            smp_we_q      <= smp_we_d;
            smp_addr_q    <= smp_addr_d;
            smp_data_q    <= smp_data_d;
            mark_found_q  <= mark_found_d;
            mark_idx_q    <= mark_idx_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pt          = pt_q;
    assign key         = key_q;
    assign ct          = ct_q;
    assign smp_we      = smp_we_q;
    assign smp_addr    = smp_addr_q;
    assign smp_data    = smp_data_q;
    assign mark_found  = mark_found_q;
    assign mark_idx    = mark_idx_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_trace_frame_rx.sv
// Scoreboard bench for trace_frame_rx: stimulus queues expected samples and
// frames, a negedge monitor pops and compares whenever the DUT presents them.
module tb_trace_frame_rx;

    localparam int NS   = 1024;
    localparam int AW   = 10;
    localparam int TMO  = 4096;
    localparam int HDR  = 48;
    localparam int FLEN = HDR + NS;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [127:0]  pt, key, ct;
    logic          smp_we;
    logic [AW-1:0] smp_addr;
    logic [7:0]    smp_data;
    logic          mark_found;
    logic [AW-1:0] mark_idx;
    logic          frame_valid, frame_err, busy;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    trace_frame_rx #(
        .PT_BYTES(16), .KEY_BYTES(16), .CT_BYTES(16),
        .SAMPLES(NS), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .DVLD_MARK(8'd255)
    ) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .pt(pt), .key(key), .ct(ct),
        .smp_we(smp_we), .smp_addr(smp_addr), .smp_data(smp_data),
        .mark_found(mark_found), .mark_idx(mark_idx),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .busy(busy), .frame_count(frame_count)
    );

    typedef struct {
        logic [127:0]  pt, key, ct;
        logic          found;
        logic [AW-1:0] idx;
        logic [15:0]   cnt;
    } frame_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } smp_t;

    frame_t      fq[$];
    smp_t        sq[$];
    int          fv_cyc[$];
    int          err_pending = 0;
    int          err_seen    = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          cyc         = 0;
    frame_t      last_exp;
    logic [15:0] exp_count;
    logic [7:0]  fb [0:1][0:FLEN-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output asserted with nothing expected at cycle %0d", name, cyc);
    endtask

    // Monitor: compare every DUT presentation against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (smp_we) begin
                if (sq.size() == 0) unexpected("smp_we");
                else begin
                    smp_t e;
                    e = sq.pop_front();
                    chk("smp_addr", smp_addr, e.addr);
                    chk("smp_data", smp_data, e.data);
                end
            end
            if (frame_valid) begin
                fv_cyc.push_back(cyc);
                if (fq.size() == 0) unexpected("frame_valid");
                else begin
                    frame_t f;
                    f = fq.pop_front();
                    chk("pt", pt, f.pt);
                    chk("key", key, f.key);
                    chk("ct", ct, f.ct);
                    chk("mark_found", mark_found, f.found);
                    chk("mark_idx", mark_idx, f.idx);
                    chk("frame_count", frame_count, f.cnt);
                    chk("fv_with_last_we", {smp_we, smp_addr}, {1'b1, AW'(NS - 1)});
                end
            end
            if (frame_err) begin
                err_seen++;
                if (err_pending == 0) unexpected("frame_err");
                else begin
                    err_pending--;
                    chk("err_pt_kept", pt, last_exp.pt);
                    chk("err_key_kept", key, last_exp.key);
                    chk("err_ct_kept", ct, last_exp.ct);
                end
            end
        end
    end

    // Fill a frame slot: header bytes base+k, samples by pattern, optional marks
    task automatic build(input int s, input logic [7:0] base, input int pat, input int m1, input int m2);
        for (int k = 0; k < HDR; k++) fb[s][k] = base + 8'(k);
        for (int i = 0; i < NS; i++) begin
            logic [7:0] d;
            d = (pat == 0) ? i[7:0] : 8'(i % 251);
            if (i == m1 || i == m2) d = 8'hFF;
            fb[s][HDR + i] = d;
        end
    endtask

    task automatic expect_frame(input int s);
        frame_t f;
        f.pt = '0; f.key = '0; f.ct = '0; f.found = 1'b0; f.idx = '0;
        for (int k = 0; k < 16; k++) begin
            f.pt  = {f.pt[119:0],  fb[s][k]};
            f.key = {f.key[119:0], fb[s][16 + k]};
            f.ct  = {f.ct[119:0],  fb[s][32 + k]};
        end
        for (int i = 0; i < NS; i++)
            if (!f.found && fb[s][HDR + i] == 8'hFF) begin
                f.found = 1'b1;
                f.idx   = AW'(i);
            end
        exp_count = exp_count + 16'd1;
        f.cnt     = exp_count;
        fq.push_back(f);
        last_exp  = f;
    endtask

    // Bytes are presented one per cycle; rx_dv stays high between calls
    task automatic send(input int s, input int from, input int to);
        for (int k = from; k < to; k++) begin
            if (k >= HDR) begin
                smp_t e;
                e.addr = AW'(k - HDR);
                e.data = fb[s][k];
                sq.push_back(e);
            end
            rx_dv   = 1'b1;
            rx_byte = fb[s][k];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_dv = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1; rx_dv = 1'b0; rx_byte = '0; exp_count = '0;
        last_exp = '{default: '0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pt", pt, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_flags", {busy, smp_we, frame_valid, frame_err, mark_found}, 0);
        rst = 1'b0;
        idle(2);
        chk("idle_busy", busy, 0);

        // Frame 1: directed header, samples = index, mark at 37
        build(0, 8'h00, 0, 37, -1);
        expect_frame(0);
        send(0, 0, 20);
        chk("busy_in_key", busy, 1);
        send(0, 20, FLEN);
        idle(3);
        chk("f1_pt", pt, 128'h000102030405060708090A0B0C0D0E0F);
        chk("f1_key", key, 128'h101112131415161718191A1B1C1D1E1F);
        chk("f1_ct", ct, 128'h202122232425262728292A2B2C2D2E2F);
        chk("f1_mark", {mark_found, mark_idx}, {1'b1, 10'd37});
        chk("f1_count", frame_count, 1);
        chk("f1_busy", busy, 0);

        // Frame 2: no 255 anywhere
        build(0, 8'h40, 1, -1, -1);
        expect_frame(0);
        send(0, 0, FLEN);
        idle(3);
        chk("f2_mark_found", mark_found, 0);

        // Frame 3: marks at 5 and 900, first one wins
        build(0, 8'h80, 1, 5, 900);
        expect_frame(0);
        send(0, 0, FLEN);
        idle(3);
        chk("f3_mark", {mark_found, mark_idx}, {1'b1, 10'd5});

        // Timeout inside KEY
        build(0, 8'hC0, 0, -1, -1);
        send(0, 0, 20);
        err_pending++;
        rx_dv = 1'b0;
        for (int i = 0; i < TMO + 20 && err_seen == 0; i++) @(posedge clk);
        #1;
        idle(5);
        chk("tmo_err_pulses", err_seen, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_pt_kept", pt, 128'h808182838485868788898A8B8C8D8E8F);
        chk("tmo_count_kept", frame_count, 3);

        // Full frame after the abort
        expect_frame(0);
        send(0, 0, FLEN);
        idle(3);
        chk("post_tmo_count", frame_count, 4);

        // Byte arriving exactly on the terminal count cycle
        build(0, 8'h11, 0, -1, 700);
        expect_frame(0);
        send(0, 0, 20);
        idle(TMO - 1);
        send(0, 20, FLEN);
        idle(3);
        chk("terminal_no_err", err_seen, 1);
        chk("terminal_count", frame_count, 5);

        // Two frames with rx_dv held high throughout
        build(0, 8'h22, 0, 300, -1);
        build(1, 8'h33, 1, -1, 1023);
        expect_frame(0);
        expect_frame(1);
        n0 = fv_cyc.size();
        send(0, 0, FLEN);
        send(1, 0, FLEN);
        idle(3);
        chk("b2b_pulses", fv_cyc.size() - n0, 2);
        if (fv_cyc.size() - n0 == 2)
            chk("b2b_spacing", fv_cyc[n0 + 1] - fv_cyc[n0], FLEN);
        chk("b2b_mark_last", {mark_found, mark_idx}, {1'b1, 10'd1023});
        chk("b2b_count", frame_count, 7);

        // Async reset mid-trace
        build(0, 8'h55, 0, 10, -1);
        send(0, 0, HDR + 500);
        rx_dv = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_pt", pt, 0);
        chk("arst_count", frame_count, 0);
        chk("arst_flags", {busy, smp_we, frame_valid, mark_found, mark_idx}, 0);
        exp_count = '0;
        last_exp  = '{default: '0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        expect_frame(0);
        send(0, 0, FLEN);
        idle(3);
        chk("post_rst_count", frame_count, 1);
        chk("post_rst_mark", {mark_found, mark_idx}, {1'b1, 10'd10});

        chk("sq_drained", sq.size(), 0);
        chk("fq_drained", fq.size(), 0);
        chk("err_drained", err_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
